// File: rtl/vfb_mc_arbiter.sv
// vfb_mc_arbiter: multi-channel DMA scheduler for the video frame buffer.
// Round-robin burst arbitration of CH_NUM writer/reader channels onto one
// DDR user interface, with per-channel rotating frame banks.
// Optional: VFB_CH0_PRIORITY_EN gives channel 0 absolute priority.
// Ports:
//   I_dma_clk, I_rst_n           clock, async active-low reset
//   I_ch_req/halt/frame_start    per-channel request, mask, frame pulse
//   I_ch_wr_data, O_ch_wr_pop    per-channel FWFT write data and pop
//   O_ch_rd_valid, O_rd_data     per-channel read strobe, shared data
//   O_ch_bank                    current bank per channel (2 bits each)
//   cmd_*, addr, app_burst_num   DDR command channel
//   wr_data_*                    DDR write data channel
//   rd_data_valid, rd_data       DDR read data channel
//   init_calib_complete          controller ready
module vfb_mc_arbiter #(
    parameter int                CH_NUM      = 4,
    parameter logic [CH_NUM-1:0] CH_DIR      = 4'b1010,
    parameter int                FRAME_NUM   = 3,
    parameter logic [31:0]       IMAGE_SIZE  = 32'h0080_0000,
    parameter int                BURST_BYTES = 1024,
    parameter int                ADDR_WIDTH  = 26,
    parameter int                DATA_WIDTH  = 128,
    parameter int                DQ_WIDTH    = 16
) (
    input  logic                         I_dma_clk,
    input  logic                         I_rst_n,
    input  logic [CH_NUM-1:0]            I_ch_req,
    input  logic [CH_NUM-1:0]            I_ch_halt,
    input  logic [CH_NUM-1:0]            I_ch_frame_start,
    input  logic [CH_NUM*DATA_WIDTH-1:0] I_ch_wr_data,
    output logic [CH_NUM-1:0]            O_ch_wr_pop,
    output logic [CH_NUM-1:0]            O_ch_rd_valid,
    output logic [DATA_WIDTH-1:0]        O_rd_data,
    output logic [CH_NUM*2-1:0]          O_ch_bank,
    input  logic                         cmd_ready,
    output logic [2:0]                   cmd,
    output logic                         cmd_en,
    output logic [5:0]                   app_burst_number,
    output logic [ADDR_WIDTH-1:0]        addr,
    input  logic                         wr_data_rdy,
    output logic                         wr_data_en,
    output logic                         wr_data_end,
    output logic [DATA_WIDTH-1:0]        wr_data,
    output logic [DATA_WIDTH/8-1:0]      wr_data_mask,
    input  logic                         rd_data_valid,
    input  logic [DATA_WIDTH-1:0]        rd_data,
    input  logic                         init_calib_complete
);

    localparam int BEATS = BURST_BYTES * 8 / DATA_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IW    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int SH    = (DQ_WIDTH / 8 > 1) ? $clog2(DQ_WIDTH / 8) : 0;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
    localparam logic [39:0]   IMG  = 40'(IMAGE_SIZE);

    typedef enum logic [1:0] {
        IDLE, CMD, WDATA, RDATA
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           gnt_q, ptr_q, ptr_nxt;
    logic [BW-1:0]           beat_q, beat_d;
    logic [2:0]              cmd_q;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [5:0]              bnum_q;
    logic [1:0]              bank_q [CH_NUM];
    logic [31:0]             off_q  [CH_NUM];
    logic [CH_NUM-1:0]       pend_q, pend_d;
    logic [CH_NUM-1:0]       fs_step, off_step;
    logic [CH_NUM-1:0]       rd_vld_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;

    logic [CH_NUM-1:0]       elig, elig_rr;
    logic                    arb_vld;
    logic [IW-1:0]           arb_idx;
    logic                    grant_now, done, wr_en;
    logic [CH_NUM-1:0]       gnt_oh;
    logic [39:0]             abyte;

    function automatic logic [1:0] bank_inc(logic [1:0] b);
        return (b == 2'(FRAME_NUM - 1)) ? 2'd0 : b + 2'd1;
    endfunction

    function automatic logic [31:0] off_inc(logic [31:0] o);
        logic [31:0] n;
        n = o + 32'(BURST_BYTES);
        return (n >= IMAGE_SIZE) ? 32'd0 : n;
    endfunction

    assign elig = I_ch_req & ~I_ch_halt;

    // Round-robin search starting at the pointer; with ch0 priority the
    // search only covers channels 1..N-1.
    always_comb begin
        logic [IW:0] j;
        arb_vld = 1'b0;
        arb_idx = '0;
        elig_rr = elig;
        j       = '0;
`ifdef VFB_CH0_PRIORITY_EN
        elig_rr[0] = 1'b0;
        if (elig[0]) begin
            arb_vld = 1'b1;
        end
`endif
        for (int i = 0; i < CH_NUM; i++) begin
            j = {1'b0, ptr_q} + (IW+1)'(i);
            if (j >= (IW+1)'(CH_NUM)) begin
                j = j - (IW+1)'(CH_NUM);
            end
            if (!arb_vld && elig_rr[j[IW-1:0]]) begin
                arb_vld = 1'b1;
                arb_idx = j[IW-1:0];
            end
        end
    end

    always_comb begin
        abyte = (40'(arb_idx) * 40'(FRAME_NUM)
                 + 40'(bank_q[arb_idx])) * IMG
                + 40'(off_q[arb_idx]);
        addr_d = ADDR_WIDTH'(abyte >> SH);
    end

    assign gnt_oh  = CH_NUM'(1) << gnt_q;
    assign ptr_nxt = (gnt_q == IW'(CH_NUM - 1)) ? '0 : gnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        cmd_en    = 1'b0;
        wr_en     = 1'b0;
        done      = 1'b0;
        grant_now = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (init_calib_complete && arb_vld) begin
                    grant_now = 1'b1;
                    state_d   = CMD;
                end
            end
            CMD: begin
                cmd_en = cmd_ready;
                if (cmd_ready) begin
                    beat_d  = '0;
                    state_d = CH_DIR[gnt_q] ? RDATA : WDATA;
                end
            end
            WDATA: begin
                wr_en = wr_data_rdy;
                if (wr_en) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            RDATA: begin
                if (rd_data_valid) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame start on the active channel is deferred to burst end so the
    // burst in flight stays inside the bank its address was taken from.
    always_comb begin
        logic act, fin;
        for (int c = 0; c < CH_NUM; c++) begin
            act = (state_q != IDLE && gnt_q == IW'(c))
                  || (grant_now && arb_idx == IW'(c));
            fin = done && gnt_q == IW'(c);
            fs_step[c]  = 1'b0;
            off_step[c] = 1'b0;
            pend_d[c]   = pend_q[c];
            if (fin) begin
                pend_d[c] = 1'b0;
                if (pend_q[c] || I_ch_frame_start[c]) begin
                    fs_step[c] = 1'b1;
                end else begin
                    off_step[c] = 1'b1;
                end
            end else if (I_ch_frame_start[c]) begin
                if (act) begin
                    pend_d[c] = 1'b1;
                end else begin
                    fs_step[c] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge I_dma_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ptr_q     <= '0;
            beat_q    <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            bnum_q    <= '0;
            pend_q    <= '0;
            rd_vld_q  <= '0;
            rd_data_q <= '0;
            for (int c = 0; c < CH_NUM; c++) begin
                bank_q[c] <= '0;
                off_q[c]  <= '0;
            end
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            pend_q  <= pend_d;
            if (grant_now) begin
                gnt_q  <= arb_idx;
                cmd_q  <= {2'b00, CH_DIR[arb_idx]};
                addr_q <= addr_d;
                bnum_q <= 6'(BEATS - 1);
            end
            if (done) begin
`ifdef VFB_CH0_PRIORITY_EN
                if (gnt_q != '0) begin
                    ptr_q <= ptr_nxt;
                end
`else
                ptr_q <= ptr_nxt;
`endif
            end
            if (state_q == RDATA && rd_data_valid) begin
                rd_vld_q  <= gnt_oh;
                rd_data_q <= rd_data;
            end else begin
                rd_vld_q  <= '0;
            end
            for (int c = 0; c < CH_NUM; c++) begin
                if (fs_step[c]) begin
                    bank_q[c] <= bank_inc(bank_q[c]);
                    off_q[c]  <= '0;
                end else if (off_step[c]) begin
                    off_q[c]  <= off_inc(off_q[c]);
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < CH_NUM; c++) begin
            O_ch_bank[c*2 +: 2] = bank_q[c];
        end
    end

    assign cmd              = cmd_q;
    assign addr             = addr_q;
    assign app_burst_number = bnum_q;
    assign wr_data_en       = wr_en;
    assign wr_data_end      = wr_en && (beat_q == LAST);
    assign wr_data          = (state_q == WDATA)
                              ? I_ch_wr_data[gnt_q*DATA_WIDTH +: DATA_WIDTH]
                              : '0;
    assign wr_data_mask     = '0;
    assign O_ch_wr_pop      = wr_en ? gnt_oh : '0;
    assign O_ch_rd_valid    = rd_vld_q;
    assign O_rd_data        = rd_data_q;

endmodule

// File: tb/tb_vfb_mc_arbiter.sv
// tb_vfb_mc_arbiter: scoreboard bench for vfb_mc_arbiter.
// Models banks, offsets and the RR pointer; checks commands and beats.
module tb_vfb_mc_arbiter;

    localparam logic [3:0] DIR = 4'b1010;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req, halt, fs;
    logic [511:0] wdata;
    logic [3:0]   O_ch_wr_pop, O_ch_rd_valid;
    logic [127:0] O_rd_data;
    logic [7:0]   O_ch_bank;
    logic         cmd_ready;
    logic [2:0]   cmd;
    logic         cmd_en;
    logic [5:0]   app_burst_number;
    logic [25:0]  addr;
    logic         wr_data_rdy, wr_data_en, wr_data_end;
    logic [127:0] wr_data;
    logic [15:0]  wr_data_mask;
    logic         rd_data_valid;
    logic [127:0] rd_data;
    logic         calib;

    vfb_mc_arbiter dut (
        .I_dma_clk           (clk),
        .I_rst_n             (rst_n),
        .I_ch_req            (req),
        .I_ch_halt           (halt),
        .I_ch_frame_start    (fs),
        .I_ch_wr_data        (wdata),
        .O_ch_wr_pop         (O_ch_wr_pop),
        .O_ch_rd_valid       (O_ch_rd_valid),
        .O_rd_data           (O_rd_data),
        .O_ch_bank           (O_ch_bank),
        .cmd_ready           (cmd_ready),
        .cmd                 (cmd),
        .cmd_en              (cmd_en),
        .app_burst_number    (app_burst_number),
        .addr                (addr),
        .wr_data_rdy         (wr_data_rdy),
        .wr_data_en          (wr_data_en),
        .wr_data_end         (wr_data_end),
        .wr_data             (wr_data),
        .wr_data_mask        (wr_data_mask),
        .rd_data_valid       (rd_data_valid),
        .rd_data             (rd_data),
        .init_calib_complete (calib)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  c;
        logic [25:0] a;
    } cmd_e_t;

    typedef struct {
        int           ch;
        logic [127:0] d;
        int           cy;
    } rd_e_t;

    cmd_e_t cmdq[$];
    rd_e_t  rdq[$];

    int bank_m[4];
    int off_m[4];
    bit pend_m[4];
    int ptr_m;
    int wcnt[4];

    function automatic logic [127:0] pat(int c, int n);
        return {8'(c), 24'(n), 32'hA5A5_0000 ^ 32'(n),
                ~32'(n), 32'(c * 7 + 1)};
    endfunction

    task automatic set_wdata(input int c);
        wdata[c*128 +: 128] = pat(c, wcnt[c]);
    endtask

    function automatic int exp_grant(logic [3:0] e);
`ifdef VFB_CH0_PRIORITY_EN
        if (e[0]) return 0;
        e[0] = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin
            int j;
            j = (ptr_m + i) % 4;
            if (e[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [25:0] exp_addr(int ch);
        longint b;
        b = (longint'(ch) * 3 + bank_m[ch]) * 64'h80_0000 + off_m[ch];
        b = b >> 1;
        return b[25:0];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            bank_m[c] = 0;
            off_m[c]  = 0;
            pend_m[c] = 0;
        end
        ptr_m = 0;
    endtask

    function automatic int bank_step(int b);
        return (b == 2) ? 0 : b + 1;
    endfunction

    always @(negedge clk) begin
        if (rst_n && O_ch_rd_valid != 4'd0) begin
            if (rdq.size() == 0) begin
                chk("rd_spurious", O_ch_rd_valid, 0);
            end else begin
                rd_e_t e;
                e = rdq.pop_front();
                chk("rd_valid", O_ch_rd_valid, 4'd1 << e.ch);
                chk("rd_data", O_rd_data, e.d);
                chk("rd_latency", cyc, e.cy + 1);
            end
        end
    end

    task automatic serve(input int stall, input int fs_at,
                         input logic [3:0] req_after);
        int ch, beats, n;
        bit got, popped, wr;
        cmd_e_t e;
        ch = exp_grant(req & ~halt);
        if (ch < 0) begin
            chk("no_grant_expected", 0, 1);
            return;
        end
        wr = !DIR[ch];
        cmdq.push_back('{c: {2'b00, DIR[ch]}, a: exp_addr(ch)});
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("cmd_en_stall", cmd_en, 0);
        end
        if (stall > 0) begin
            @(posedge clk); #1;
            cmd_ready = 1'b1;
        end
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (cmd_en) got = 1;
        end
        e = cmdq.pop_front();
        if (!got) begin
            chk("cmd_timeout", 0, 1);
            return;
        end
        chk("cmd", cmd, e.c);
        chk("addr", addr, e.a);
        chk("burst_num", app_burst_number, 63);
        beats  = 0;
        popped = 0;
        n      = 0;
        while (beats < 64 && n < 1000) begin
            @(posedge clk); #1;
            if (n == 0) req = req_after;
            if (popped) begin
                wcnt[ch]++;
                set_wdata(ch);
                popped = 0;
            end
            fs = (fs_at >= 0 && (n == fs_at || n == fs_at + 3))
                 ? 4'd1 << ch : 4'd0;
            if (wr) begin
                wr_data_rdy = ($urandom_range(0, 3) != 0);
            end else begin
                rd_data_valid = ($urandom_range(0, 3) != 0);
                if (rd_data_valid) begin
                    rd_data = {$urandom, $urandom, $urandom, $urandom};
                    rdq.push_back('{ch: ch, d: rd_data, cy: cyc});
                    beats++;
                end
            end
            @(negedge clk);
            if (n == 0) chk("cmd_en_once", cmd_en, 0);
            if (wr) begin
                chk("wr_pop", O_ch_wr_pop,
                    wr_data_en ? 4'd1 << ch : 4'd0);
                if (wr_data_en) begin
                    chk("wr_data", wr_data, pat(ch, wcnt[ch]));
                    chk("wr_end", wr_data_end, beats == 63);
                    beats++;
                    popped = 1;
                end
            end
            if (fs_at >= 0 && n == fs_at + 6) begin
                chk("bank_hold", O_ch_bank[ch*2 +: 2], bank_m[ch]);
            end
            n++;
        end
        @(posedge clk); #1;
        if (popped) begin
            wcnt[ch]++;
            set_wdata(ch);
        end
        wr_data_rdy   = 1'b0;
        rd_data_valid = 1'b0;
        fs            = 4'd0;
        chk("burst_beats", beats, 64);
        if (fs_at >= 0) pend_m[ch] = 1;
        if (pend_m[ch]) begin
            bank_m[ch] = bank_step(bank_m[ch]);
            off_m[ch]  = 0;
            pend_m[ch] = 0;
        end else begin
            off_m[ch] += 1024;
            if (off_m[ch] >= 32'h80_0000) off_m[ch] = 0;
        end
`ifdef VFB_CH0_PRIORITY_EN
        if (ch != 0) ptr_m = (ch + 1) % 4;
`else
        ptr_m = (ch + 1) % 4;
`endif
    endtask

    task automatic pulse_fs(input int ch);
        fs = 4'd1 << ch;
        @(posedge clk); #1;
        fs = 4'd0;
        bank_m[ch] = bank_step(bank_m[ch]);
        off_m[ch]  = 0;
        @(negedge clk);
        chk("bank_fs", O_ch_bank[ch*2 +: 2], bank_m[ch]);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req = '0; halt = '0; fs = '0;
        cmd_ready = 1'b1; wr_data_rdy = 1'b0;
        rd_data_valid = 1'b0; rd_data = '0;
        calib = 1'b0;
        for (int c = 0; c < 4; c++) begin
            wcnt[c] = 0;
            set_wdata(c);
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_en", cmd_en, 0);
        chk("rst_wr_en", wr_data_en, 0);
        chk("rst_wr_end", wr_data_end, 0);
        chk("rst_wr_pop", O_ch_wr_pop, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_mask", wr_data_mask, 0);
        chk("rst_rd_valid", O_ch_rd_valid, 0);
        chk("rst_rd_data", O_rd_data, 0);
        chk("rst_bank", O_ch_bank, 0);
        chk("rst_addr", addr, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_bnum", app_burst_number, 0);

        @(posedge clk); #1;
        req = 4'b0001;
        repeat (5) begin
            @(negedge clk);
            chk("nocal_cmd_en", cmd_en, 0);
            chk("nocal_bnum", app_burst_number, 0);
        end
        @(posedge clk); #1;
        calib = 1'b1;
        serve(0, -1, 4'b0000);

        req = 4'b0010;
        serve(0, -1, 4'b0000);

        req = 4'b1011; halt = 4'b1000;
        repeat (4) serve(0, -1, 4'b1011);
        halt = 4'b0000;
        repeat (3) serve(0, -1, 4'b1011);
        serve(0, -1, 4'b0000);

        repeat (2) @(posedge clk);
        #1;
        pulse_fs(0);
        req = 4'b0001;
        serve(0, -1, 4'b0000);
        pulse_fs(0);
        pulse_fs(0);

        req = 4'b0001;
        serve(0, 5, 4'b0000);
        @(negedge clk);
        chk("bank_after_pend", O_ch_bank[1:0], bank_m[0]);
        @(posedge clk); #1;
        req = 4'b0001;
        serve(0, -1, 4'b0000);

        cmd_ready = 1'b0;
        req = 4'b0100;
        serve(10, -1, 4'b0000);

        req = 4'b0101;
        serve(0, -1, 4'b0101);
        serve(0, -1, 4'b0000);

        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            rd_data_valid = (i < 3);
            rd_data = 128'hDEAD;
            @(negedge clk);
            chk("rd_drop", O_ch_rd_valid, 0);
        end
        @(posedge clk); #1;
        rd_data_valid = 1'b0;

        req = 4'b0001;
        wr_data_rdy = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        req = 4'b0000;
        chk("bank_pre_rst", O_ch_bank[1:0], bank_m[0]);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", wr_data_en, 0);
        chk("mid_rst_pop", O_ch_wr_pop, 0);
        chk("mid_rst_cmd_en", cmd_en, 0);
        chk("mid_rst_bank", O_ch_bank, 0);
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_bnum", app_burst_number, 0);
        wr_data_rdy = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rd_drain", rdq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
